mkio_receiver: RTL and testbench

Manchester-II word decoder for the MKIO (MIL-STD-1553-style) bus interface, the receive-side counterpart of the transmitter stage. It takes the differential line pair driven by the transmitter or bus transceiver, detects the command/data sync, and samples 34 data and parity half-bit elements. It checks Manchester validity and odd parity, then delivers one 16-bit word with a single-cycle strobe to the protocol layer.

---
 rtl/mkio_receiver.sv | 204 ++++++++++++++++++++
 tb/tb_mkio_receiver.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mkio_receiver.sv
// mkio_receiver: Manchester-II word decoder for the MKIO line pair.
// Detects the command/data sync, samples 34 data/parity elements and
// delivers one 16-bit word with a one-cycle strobe plus error flags.
// Optional build macro: MKIO_RCV_GLITCH_FILTER_EN adds a 3-tap majority
// filter on each synchronized line (one extra cycle of latency).
//
// state | meaning
// IDLE  | waiting; arms on an idle (00) line, starts on high/low when armed
// SYNC1 | timing the first sync half at level L
// SYNC2 | second sync half, no sampling
// DATA  | sampling 34 elements at mid-element
// DONE  | one-cycle strobe, outputs just updated
`timescale 1ns/1ps

module mkio_receiver #(
   parameter int HALF_BIT = 8,
   parameter int SYNC_TOL = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        DI1,
   input  logic        DI0,
   output logic [15:0] data_rcv,
   output logic        cd_rcv,
   output logic        err_parity,
   output logic        err_manchester,
   output logic        imp_rcv,
   output logic        busy_rcv
);

   localparam int SYNC_NOM = 3 * HALF_BIT;
   localparam int CW       = $clog2(SYNC_NOM + SYNC_TOL + 2);

   localparam logic [CW-1:0] SYNC_MIN    = CW'(SYNC_NOM - SYNC_TOL);
   localparam logic [CW-1:0] SYNC_MAX    = CW'(SYNC_NOM + SYNC_TOL);
   // t0 itself is the first second-half cycle, so SYNC2 spans cnt = NOM-2 .. 0
   localparam logic [CW-1:0] SYNC2_LOAD  = CW'(SYNC_NOM - 2);
   localparam logic [CW-1:0] SAMPLE_LOAD = CW'(HALF_BIT / 2);
   localparam logic [CW-1:0] ELEM_LOAD   = CW'(HALF_BIT - 1);
   localparam logic [5:0]    LAST_EL     = 6'd33;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SYNC1 = 3'd1,
      SYNC2 = 3'd2,
      DATA  = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t      state, nxt;
   logic [1:0]  sync_a, sync_b;
   logic [1:0]  line;
   logic        armed;
   logic        lvl_hi;
   logic [1:0]  lvl_code, inv_code;
   logic [CW-1:0] cnt;
   logic [5:0]  el;
   logic [16:0] shreg;
   logic        first;
   logic        merr;
   logic        smp_val, smp_bad, merr_pair;

   // Two-flop synchronizer; stages reset to the invalid code so a reset in
   // the middle of a word cannot arm on a fake idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_a <= 2'b11;
         sync_b <= 2'b11;
      end else begin
         sync_a <= {DI1, DI0};
         sync_b <= sync_a;
      end
   end

`ifdef MKIO_RCV_GLITCH_FILTER_EN
   logic [1:0] hist1, hist2;

   // History taps for the per-line majority vote.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hist1 <= 2'b11;
         hist2 <= 2'b11;
      end else begin
         hist1 <= sync_b;
         hist2 <= hist1;
      end
   end

   assign line = (sync_b & hist1) | (sync_b & hist2) | (hist1 & hist2);
`else
   assign line = sync_b;
`endif

   assign lvl_code  = lvl_hi ? 2'b10 : 2'b01;
   assign inv_code  = lvl_hi ? 2'b01 : 2'b10;
   assign smp_val   = line[1];
   assign smp_bad   = (line[1] == line[0]);
   assign merr_pair = merr | smp_bad | (smp_val == first);

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= nxt;
   end

   // Next-state decode; busy covers the cycle that starts a sync so it rises
   // together with the first non-idle synchronized line cycle.
   always_comb begin
      nxt      = state;
      busy_rcv = 1'b0;
      unique case (state)
         IDLE: begin
            if (armed && (line == 2'b10 || line == 2'b01)) begin
               nxt      = SYNC1;
               busy_rcv = 1'b1;
            end
         end
         SYNC1: begin
            busy_rcv = 1'b1;
            if (line == lvl_code) begin
               if (cnt == SYNC_MAX) nxt = IDLE;
            end else if (line == inv_code) begin
               nxt = (cnt >= SYNC_MIN) ? SYNC2 : IDLE;
            end else begin
               nxt = IDLE;
            end
         end
         SYNC2: begin
            busy_rcv = 1'b1;
            if (cnt == '0) nxt = DATA;
         end
         DATA: begin
            busy_rcv = 1'b1;
            if (cnt == '0 && el == LAST_EL) nxt = DONE;
         end
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // Timers, element sampling and registered word outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         armed          <= 1'b0;
         lvl_hi         <= 1'b0;
         cnt            <= '0;
         el             <= '0;
         shreg          <= '0;
         first          <= 1'b0;
         merr           <= 1'b0;
         data_rcv       <= '0;
         cd_rcv         <= 1'b0;
         err_parity     <= 1'b0;
         err_manchester <= 1'b0;
         imp_rcv        <= 1'b0;
      end else begin
         imp_rcv <= 1'b0;
         unique case (state)
            IDLE: begin
               if (line == 2'b00) armed <= 1'b1;
               if (nxt == SYNC1) begin
                  armed  <= 1'b0;
                  lvl_hi <= line[1];
                  cnt    <= CW'(1);
               end
            end
            SYNC1: cnt <= (nxt == SYNC2) ? SYNC2_LOAD : cnt + CW'(1);
            SYNC2: begin
               if (cnt == '0) begin
                  cnt  <= SAMPLE_LOAD;
                  el   <= '0;
                  merr <= 1'b0;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            DATA: begin
               if (cnt != '0) begin
                  cnt <= cnt - CW'(1);
               end else begin
                  cnt <= ELEM_LOAD;
                  el  <= el + 6'd1;
                  if (!el[0]) begin
                     shreg <= {shreg[15:0], smp_val};
                     first <= smp_val;
                     merr  <= merr | smp_bad;
                  end else begin
                     merr <= merr_pair;
                  end
                  if (el == LAST_EL) begin
                     data_rcv       <= shreg[16:1];
                     cd_rcv         <= ~lvl_hi;
                     err_parity     <= ~^shreg;
                     err_manchester <= merr_pair;
                     imp_rcv        <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mkio_receiver.sv
// tb_mkio_receiver: drives Manchester words on DI1/DI0 and checks decoded
// words against a scoreboard of expected results and strobe cycles.
`timescale 1ns/1ps

module tb_mkio_receiver;

   localparam int HB = 8;
`ifdef MKIO_RCV_GLITCH_FILTER_EN
   localparam int LAT = 320;
`else
   localparam int LAT = 319;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        DI1, DI0;
   logic [15:0] data_rcv;
   logic        cd_rcv, err_parity, err_manchester, imp_rcv, busy_rcv;

   mkio_receiver #(.HALF_BIT(HB), .SYNC_TOL(4)) dut (
      .clk            (clk),
      .reset          (reset),
      .DI1            (DI1),
      .DI0            (DI0),
      .data_rcv       (data_rcv),
      .cd_rcv         (cd_rcv),
      .err_parity     (err_parity),
      .err_manchester (err_manchester),
      .imp_rcv        (imp_rcv),
      .busy_rcv       (busy_rcv)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;
   int n_exp    = 0;
   int n_strobe = 0;

   typedef struct {
      logic [15:0] data;
      logic        cd;
      logic        ep;
      logic        em;
      int          t;
   } exp_t;

   exp_t sb[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard side: every strobe must match the oldest expected word.
   always @(negedge clk) begin
      exp_t e;
      if (imp_rcv === 1'b1) begin
         n_strobe++;
         if (sb.size() == 0) begin
            check("unexpected_strobe", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check("data_rcv",       {16'd0, data_rcv}, {16'd0, e.data});
            check("cd_rcv",         {31'd0, cd_rcv}, {31'd0, e.cd});
            check("err_parity",     {31'd0, err_parity}, {31'd0, e.ep});
            check("err_manchester", {31'd0, err_manchester}, {31'd0, e.em});
            check("strobe_cycle",   cyc, e.t);
         end
      end
   end

   task automatic check_zero_outputs(input string tag);
      check({tag, "_data"}, {16'd0, data_rcv}, 32'd0);
      check({tag, "_cd"},   {31'd0, cd_rcv}, 32'd0);
      check({tag, "_ep"},   {31'd0, err_parity}, 32'd0);
      check({tag, "_em"},   {31'd0, err_manchester}, 32'd0);
      check({tag, "_imp"},  {31'd0, imp_rcv}, 32'd0);
      check({tag, "_busy"}, {31'd0, busy_rcv}, 32'd0);
   endtask

   // mode: 0 normal, 1 parity pair inverted, 2 element 10 forced to 11,
   //       3 short first sync half, 4 reset pulse at T+150, 5 DI1 spikes
   task automatic send_word(input logic [15:0] d, input logic cd, input int mode,
                            input int gap, input logic expect_strobe);
      logic [1:0]  els[34];
      logic [1:0]  wave[$];
      logic [1:0]  lvl;
      logic [16:0] bits;
      logic        p, b, mm;
      int          t0c, base;
      exp_t        e;

      p = (mode == 1) ? ^d : ~^d;
      for (int j = 0; j < 17; j++) begin
         b = (j < 16) ? d[15-j] : p;
         els[2*j]   = {b, ~b};
         els[2*j+1] = {~b, b};
      end
      if (mode == 2) els[10] = 2'b11;

      // Decode the line as the receiver should see it at mid-element.
      mm   = 1'b0;
      bits = '0;
      for (int j = 0; j < 17; j++) begin
         bits = {bits[15:0], els[2*j][1]};
         if (els[2*j][1] == els[2*j][0] || els[2*j+1][1] == els[2*j+1][0] ||
             els[2*j][1] == els[2*j+1][1])
            mm = 1'b1;
      end

      lvl = cd ? 2'b01 : 2'b10;
      repeat ((mode == 3) ? 16 : 3*HB) wave.push_back(lvl);
      repeat (3*HB) wave.push_back(~lvl);
      base = wave.size();
      for (int k = 0; k < 34; k++) repeat (HB) wave.push_back(els[k]);
      if (mode == 5)
         for (int k = 0; k < 34; k += 3) wave[base + k*HB + 2] = wave[base + k*HB + 2] ^ 2'b10;
      repeat (gap) wave.push_back(2'b00);

      @(posedge clk); #1;
      t0c = cyc;
      if (expect_strobe) begin
         e.data = bits[16:1];
         e.cd   = cd;
         e.ep   = ~^bits;
         e.em   = mm;
         e.t    = t0c + LAT;
         sb.push_back(e);
         n_exp++;
      end

      for (int i = 0; i < wave.size(); i++) begin
         {DI1, DI0} = wave[i];
         if (mode != 3 && mode != 4) begin
            if (i == LAT - 318) check("busy_before", {31'd0, busy_rcv}, 32'd0);
            if (i == LAT - 317) check("busy_rise",   {31'd0, busy_rcv}, 32'd1);
            if (i == 150)       check("busy_mid",    {31'd0, busy_rcv}, 32'd1);
            if (i == LAT - 1)   check("busy_last",   {31'd0, busy_rcv}, 32'd1);
            if (i == LAT)       check("busy_fall",   {31'd0, busy_rcv}, 32'd0);
         end
         if (mode == 3) begin
            if (i == 10) check("abort_busy_before", {31'd0, busy_rcv}, 32'd1);
            if (i == 30) check("abort_busy_after",  {31'd0, busy_rcv}, 32'd0);
         end
         if (mode == 4) begin
            if (i == 150) reset = 1'b1;
            if (i == 151) begin
               check_zero_outputs("midreset");
               reset = 1'b0;
            end
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      reset = 1'b1;
      DI1   = 1'b0;
      DI0   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_zero_outputs("reset");
      reset = 1'b0;
      repeat (5) @(posedge clk);

      send_word(16'hA5C3, 1'b1, 0, 10, 1'b1);
      send_word(16'h0000, 1'b0, 0, 1,  1'b1);
      send_word(16'hFFFF, 1'b0, 0, 10, 1'b1);
      send_word(16'h1234, 1'b0, 1, 10, 1'b1);
      send_word(16'h00FF, 1'b1, 2, 10, 1'b1);
      send_word(16'h5A5A, 1'b1, 3, 5,  1'b0);
      send_word(16'h5A5A, 1'b1, 0, 10, 1'b1);
      send_word(16'h1234, 1'b1, 4, 5,  1'b0);
      send_word(16'hC001, 1'b0, 0, 10, 1'b1);
`ifdef MKIO_RCV_GLITCH_FILTER_EN
      send_word(16'hA5C3, 1'b1, 5, 10, 1'b1);
`endif

      repeat (20) @(posedge clk);
      #1;
      check("pending_words", sb.size(), 32'd0);
      check("strobe_count", n_strobe, n_exp);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
